sa_row_collector: RTL
=====================

Name: sa_row_collector

Overview:
- Receive side of the systolic-array row strobe interface.
- The row strobe is a one-hot pulse that rotates row 0..ROW-1, one row per cycle, while enable is high.
- This block samples each strobed row's result word from the flattened array output bus and encodes the one-hot strobe to a row index.
- It buffers {index, last, data} in a small FIFO and presents it as a valid/ready stream to the readout/DMA logic.

Parameters:
- ROW, 9, number of array rows; width of the strobe.
- DW, 16, result word width per row.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  collection enable; low means synchronous flush.
- i_row_strobe  input  ROW  one-hot row strobe; bit k selects row k.
- i_row_data  input  ROW*DW  flattened row results; row k occupies bits [k*DW +: DW].
- o_data  output  DW  head-of-FIFO word.
- o_row_idx  output  clog2(ROW)  row index of the head word.
- o_last  output  1  head word came from row ROW-1.
- o_valid  output  1  FIFO not empty.
- i_ready  input  1  consumer accepts the head word.
- o_full  output  1  FIFO count equals DEPTH.
- o_overflow  output  1  sticky; a valid strobe was dropped because the FIFO was full.
- o_seq_err  output  1  sticky sequence error; see Optional Feature.

Behaviour:
- Reset (async assert): FIFO empty; count 0; all outputs 0; sticky flags 0. Release is synchronous to i_clk.
- Strobe classification, evaluated each edge while i_enable=1:
  - Zero: idle, no push.
  - Exactly one bit k set: push request.
  - More than one bit set: invalid, no push.
- Push: writes {k, k==ROW-1, i_row_data[k*DW +: DW]} at the edge where the strobe is high.
- Latency: a push at edge N into an empty FIFO gives o_valid=1 with that data from edge N onward (FWFT), 1 cycle.
- Pop: happens when o_valid && i_ready at an edge; the head advances.
- o_data, o_row_idx and o_last stay stable while o_valid=1 and i_ready=0.
- Full with push only: word dropped; o_overflow set to 1; count unchanged.
- Full with push and pop in the same cycle: push accepted; count stays DEPTH; no overflow.
- Empty with pop: impossible, since o_valid=0.
- Empty with push and i_ready=1 in the same cycle: no bypass; the word appears the next cycle.
- Pointers: wrap modulo DEPTH. The count register is clog2(DEPTH)+1 bits.
- i_enable=0 (synchronous): FIFO emptied, o_overflow and o_seq_err cleared, strobe ignored. This is the same cycle-level behaviour as the strobe generator's disable.
- i_enable falling mid-stream discards pending words. The consumer must see o_valid drop without handshake.
- Mid-operation reset: identical to the power-on reset state.

Optional Feature:
- Macro: SA_ROW_SEQ_CHECK_EN.
- Defined:
  - An expected-row counter resets to 0, is cleared by i_enable=0, and advances (ROW-1 wraps to 0) on every one-hot strobe, including dropped ones.
  - A one-hot strobe with k != expected sets o_seq_err; the word is still pushed and the expected counter resyncs to k+1 (wrap).
  - A multi-hot strobe sets o_seq_err.
- Not defined: o_seq_err tied 0; no counter logic is synthesized.

Decomposition:
- Package sa_pkg: clog2 function, ROW_IDX_W derived constant, struct/typedef row_entry_t {idx, last, data}.
- Sub-module sa_row_fifo: parameterized synchronous FWFT FIFO providing push, pop, full, empty and count.
- The top level holds the one-hot encoder, validity check, sticky flags and the optional sequence checker.

Test Plan:
- ROW=9, DW=16, DEPTH=4; i_ready=1; one strobe rotation 0..8 with row k data 16'h1000+k -> 9 words in order, idx 0..8, data 16'h1000..16'h1008, o_last only on idx 8, no flags.
- i_ready=0 with strobes on rows 0..5 -> o_full after the 4th push; rows 4 and 5 dropped; o_overflow=1. Then i_ready=1 -> exactly 4 words, idx 0..3, in order.
- Full FIFO with i_ready=1 and a strobe in the same cycle -> count stays 4, word accepted, o_overflow stays 0.
- Strobe 9'b000010100 -> no push. With SA_ROW_SEQ_CHECK_EN, o_seq_err=1; without it, o_seq_err=0.
- SA_ROW_SEQ_CHECK_EN with strobes rows 0,1,3 -> o_seq_err set at row 3; row 3 still output. The next strobe, row 4, raises no new error.
- 3 words buffered, then i_enable=0 for 1 cycle -> o_valid=0 and flags cleared the next cycle. Async i_rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants, clog2 helper and row entry type for the row collector
package sa_pkg;

    localparam int ROW_DEFAULT = 9;
    localparam int DW_DEFAULT  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int ROW_IDX_W = clog2(ROW_DEFAULT);

    typedef struct packed {
        logic [ROW_IDX_W-1:0]  idx;
        logic                  last;
        logic [DW_DEFAULT-1:0] data;
    } row_entry_t;

endpackage

// File: rtl/sa_row_collector_if.sv
// rtl/sa_row_collector_if.sv - readout stream (head word, index, last, valid/ready)
interface sa_row_collector_if
    import sa_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int IDX_W = ROW_IDX_W
);
    logic [DW-1:0]    o_data;
    logic [IDX_W-1:0] o_row_idx;
    logic             o_last;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output o_data,
        output o_row_idx,
        output o_last,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_row_idx,
        input  o_last,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/sa_row_fifo.sv
// rtl/sa_row_fifo.sv - synchronous first-word-fall-through FIFO with flush and occupancy count
module sa_row_fifo
    import sa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/sa_row_collector.sv
// rtl/sa_row_collector.sv - samples strobed systolic row results into a FIFO stream; SA_ROW_SEQ_CHECK_EN adds row-order checking
module sa_row_collector
    import sa_pkg::*;
#(
    parameter int ROW   = ROW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [ROW-1:0]      i_row_strobe,
    input  logic [ROW*DW-1:0]   i_row_data,
    sa_row_collector_if.master  rd,
    output logic                o_full,
    output logic                o_overflow,
    output logic                o_seq_err
);
    localparam int IDX_W = clog2(ROW);
    localparam int EW    = IDX_W + 1 + DW;

    logic             one_hot, multi_hot, push_req;
    logic [IDX_W-1:0] enc_idx;
    logic [DW-1:0]    enc_data;
    logic             enc_last;
    logic [EW-1:0]    head;
    logic             fifo_full, fifo_empty;
    logic [clog2(DEPTH):0] fifo_count;
    logic             overflow_q, overflow_d;

    assign one_hot   = (|i_row_strobe) && ((i_row_strobe & (i_row_strobe - ROW'(1))) == '0);
    assign multi_hot = (|i_row_strobe) && !one_hot;
    assign push_req  = i_enable && one_hot;
    assign enc_last  = (enc_idx == IDX_W'(ROW - 1));

    // OR-reduction encoder; only meaningful when the strobe is one-hot.
    always_comb begin
        enc_idx  = '0;
        enc_data = '0;
        for (int k = 0; k < ROW; k++) begin
            if (i_row_strobe[k]) begin
                enc_idx  = enc_idx | IDX_W'(k);
                enc_data = enc_data | i_row_data[k*DW +: DW];
            end
        end
    end

    sa_row_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .flush (!i_enable),
        .push  (push_req),
        .pop   (rd.i_ready),
        .wdata ({enc_idx, enc_last, enc_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd.o_valid   = !fifo_empty;
    assign rd.o_data    = fifo_empty ? '0 : head[DW-1:0];
    assign rd.o_last    = fifo_empty ? 1'b0 : head[DW];
    assign rd.o_row_idx = fifo_empty ? '0 : head[EW-1 -: IDX_W];
    assign o_full       = (fifo_count == (clog2(DEPTH) + 1)'(DEPTH));
    assign o_overflow   = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (!i_enable) begin
            overflow_d = 1'b0;
        end else if (push_req && fifo_full && !rd.i_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

`ifdef SA_ROW_SEQ_CHECK_EN
    logic [IDX_W-1:0] exp_q, exp_d;
    logic             seq_err_q, seq_err_d;

    // Expected row tracks every one-hot strobe, dropped or not, and resyncs on a skip.
    always_comb begin
        exp_d     = exp_q;
        seq_err_d = seq_err_q;
        if (!i_enable) begin
            exp_d     = '0;
            seq_err_d = 1'b0;
        end else if (one_hot) begin
            if (enc_idx != exp_q) begin
                seq_err_d = 1'b1;
            end
            exp_d = enc_last ? '0 : enc_idx + IDX_W'(1);
        end else if (multi_hot) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            exp_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            exp_q     <= exp_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign o_seq_err = seq_err_q;
`else
    logic unused_multi_hot;
    assign unused_multi_hot = multi_hot;
    assign o_seq_err        = 1'b0;
`endif
endmodule
